// File: rtl/my_risc16.sv
// my_risc16: multi-cycle RiSC-16 core with an internal 64K x 16 unified memory.
// Each instruction runs FETCH -> EXEC (-> MEM for loads/stores); HALT is terminal.
module my_risc16 (
    input  logic clk,
    input  logic rstn,
    output logic halt
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    reg [15:0] mem [0:65535];

    state_t      state, next_state;
    logic [15:0] pc, ir, ea;
    logic [15:0] rf [0:7];

    logic [2:0]  op, ra, rb, rc;
    logic [15:0] simm, lui_val, va, vb, vc, wb_data;
    logic        is_mem, is_halt, wb_en, mem_we;

    assign op      = ir[15:13];
    assign ra      = ir[12:10];
    assign rb      = ir[9:7];
    assign rc      = ir[2:0];
    assign simm    = {{9{ir[6]}}, ir[6:0]};
    assign lui_val = {ir[9:0], 6'b0};

    assign va = (ra == 3'd0) ? 16'h0000 : rf[ra];
    assign vb = (rb == 3'd0) ? 16'h0000 : rf[rb];
    assign vc = (rc == 3'd0) ? 16'h0000 : rf[rc];

    assign is_mem  = (op == OP_SW) || (op == OP_LW);
    assign is_halt = (op == OP_JALR) && (ir[6:0] != 7'd0);
    assign mem_we  = (state == S_MEM) && (op == OP_SW);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                if (is_halt)
                    next_state = S_HALT;
                else if (is_mem)
                    next_state = S_MEM;
                else
                    next_state = S_FETCH;
            end
            S_MEM:   next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // pc already holds PC+1 during EXEC, so it is the JALR link value.
    always_comb begin
        wb_en   = 1'b0;
        wb_data = 16'h0000;
        if (state == S_EXEC) begin
            case (op)
                OP_ADD:  begin wb_en = 1'b1; wb_data = vb + vc;    end
                OP_ADDI: begin wb_en = 1'b1; wb_data = vb + simm;  end
                OP_NAND: begin wb_en = 1'b1; wb_data = ~(vb & vc); end
                OP_LUI:  begin wb_en = 1'b1; wb_data = lui_val;    end
                OP_JALR: begin
                    if (!is_halt) begin
                        wb_en   = 1'b1;
                        wb_data = pc;
                    end
                end
                default: ;
            endcase
        end else if ((state == S_MEM) && (op == OP_LW)) begin
            wb_en   = 1'b1;
            wb_data = mem[ea];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc   <= 16'h0000;
            ir   <= 16'h0000;
            ea   <= 16'h0000;
            halt <= 1'b0;
            for (int i = 0; i < 8; i++)
                rf[i] <= 16'h0000;
        end else begin
            if (wb_en && (ra != 3'd0))
                rf[ra] <= wb_data;
            case (state)
                S_FETCH: begin
                    ir <= mem[pc];
                    pc <= pc + 16'd1;
                end
                S_EXEC: begin
                    if ((op == OP_BEQ) && (va == vb))
                        pc <= pc + simm;
                    if ((op == OP_JALR) && !is_halt)
                        pc <= vb;
                    if (is_mem)
                        ea <= vb + simm;
                    if (is_halt)
                        halt <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory is never reset so it can be preloaded; writes only come from the MEM state.
    always @(posedge clk) begin
        if (mem_we)
            mem[ea] <= va;
    end
endmodule

// File: tb/tb_my_risc16.sv
// Testbench for my_risc16: directed program table, timing sequences and
// randomized straight-line programs against an instruction-level model.
module tb_my_risc16;
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic halt;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    my_risc16 dut (.clk(clk), .rstn(rstn), .halt(halt));

    typedef struct {
        string       name;
        logic [15:0] p0, p1, p2, p3, p4, p5;
        int          ridx;
        logic [15:0] expv;
        int          cyc;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearMem();
        for (int a = 0; a < 128; a++)
            dut.mem[16'(a)] = 16'h0000;
        dut.mem[16'hFFFF] = 16'h0000;
    endtask

    task automatic holdReset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Releases reset and counts rising edges until halt is seen (bounded).
    task automatic runToHalt(output int cyc);
        cyc = 0;
        @(negedge clk);
        rstn = 1'b1;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (halt) break;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int cyc;
        holdReset(2);
        clearMem();
        dut.mem[0] = v.p0; dut.mem[1] = v.p1; dut.mem[2] = v.p2;
        dut.mem[3] = v.p3; dut.mem[4] = v.p4; dut.mem[5] = v.p5;
        runToHalt(cyc);
        checkOutput({v.name, " halted"}, 32'(halt), 32'd1);
        checkOutput({v.name, " reg"}, 32'(dut.rf[v.ridx]), 32'(v.expv));
        checkOutput({v.name, " cycles"}, cyc, v.cyc);
    endtask

    task automatic randomProgram(input int n);
        logic [15:0] m_r [8];
        logic [15:0] m_d [32];
        int          exp_cyc;
        int          cyc;
        exp_cyc = 2;
        for (int i = 0; i < 8; i++)  m_r[i] = 16'h0;
        for (int i = 0; i < 32; i++) m_d[i] = 16'h0;
        holdReset(2);
        clearMem();
        for (int i = 0; i < 20; i++) begin
            int          kind;
            logic [2:0]  a, b, c;
            logic [6:0]  im;
            logic [3:0]  junk;
            logic [15:0] w, sx;
            kind = $urandom_range(0, 5);
            a    = 3'($urandom_range(0, 7));
            b    = 3'($urandom_range(0, 7));
            c    = 3'($urandom_range(0, 7));
            im   = 7'($urandom);
            junk = 4'($urandom);
            sx   = {{9{im[6]}}, im};
            w    = 16'h0;
            case (kind)
                0: begin w = {3'd0, a, b, junk, c}; m_r[a] = m_r[b] + m_r[c];    exp_cyc += 2; end
                1: begin w = {3'd1, a, b, im};      m_r[a] = m_r[b] + sx;        exp_cyc += 2; end
                2: begin w = {3'd2, a, b, junk, c}; m_r[a] = ~(m_r[b] & m_r[c]); exp_cyc += 2; end
                3: begin w = {3'd3, a, b, im};      m_r[a] = {b, im, 6'b0};      exp_cyc += 2; end
                4: begin
                    im = 7'(32 + $urandom_range(0, 31));
                    w  = {3'd4, a, 3'd0, im};
                    m_d[int'(im) - 32] = m_r[a];
                    exp_cyc += 3;
                end
                default: begin
                    im = 7'(32 + $urandom_range(0, 31));
                    w  = {3'd5, a, 3'd0, im};
                    m_r[a] = m_d[int'(im) - 32];
                    exp_cyc += 3;
                end
            endcase
            m_r[0] = 16'h0;
            dut.mem[16'(i)] = w;
        end
        dut.mem[20] = 16'hE001;
        runToHalt(cyc);
        checkOutput($sformatf("rand%0d cycles", n), cyc, exp_cyc);
        for (int r = 0; r < 8; r++)
            checkOutput($sformatf("rand%0d r%0d", n, r), 32'(dut.rf[r]), 32'(m_r[r]));
        for (int d = 0; d < 32; d++)
            checkOutput($sformatf("rand%0d mem%0d", n, d + 32), 32'(dut.mem[16'(d + 32)]), 32'(m_d[d]));
    endtask

    initial begin
        int          cyc;
        int          bad;
        logic [15:0] pc_snap;

        vecs[0]  = '{"arith_r1",  16'h2405, 16'h287F, 16'h0C82, 16'hE001, 16'h0000, 16'h0000, 1, 16'h0005, 8};
        vecs[1]  = '{"arith_r2",  16'h2405, 16'h287F, 16'h0C82, 16'hE001, 16'h0000, 16'h0000, 2, 16'hFFFF, 8};
        vecs[2]  = '{"arith_r3",  16'h2405, 16'h287F, 16'h0C82, 16'hE001, 16'h0000, 16'h0000, 3, 16'h0004, 8};
        vecs[3]  = '{"lui",       16'h73FF, 16'hE001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4, 16'hFFC0, 4};
        vecs[4]  = '{"nand",      16'h73FF, 16'h5604, 16'hE001, 16'h0000, 16'h0000, 16'h0000, 5, 16'h003F, 6};
        vecs[5]  = '{"r0_write",  16'h2007, 16'hE001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 4};
        vecs[6]  = '{"sw_lw",     16'h2405, 16'h8410, 16'hB410, 16'hE001, 16'h0000, 16'h0000, 5, 16'h0005, 10};
        vecs[7]  = '{"beq_taken", 16'h2405, 16'hC001, 16'h2801, 16'hE001, 16'h0000, 16'h0000, 2, 16'h0000, 6};
        vecs[8]  = '{"beq_not",   16'h2405, 16'hC401, 16'h2801, 16'hE001, 16'h0000, 16'h0000, 2, 16'h0001, 8};
        vecs[9]  = '{"beq_loop",  16'h2403, 16'h24FF, 16'hC401, 16'hC07D, 16'hE001, 16'h0000, 1, 16'h0000, 20};
        vecs[10] = '{"jalr",      16'h3804, 16'hFF00, 16'h2C01, 16'hE001, 16'hE001, 16'h0000, 7, 16'h0002, 6};
        vecs[11] = '{"jalr_same", 16'h3804, 16'hFB00, 16'h2C01, 16'hE001, 16'hE001, 16'h0000, 6, 16'h0002, 6};
        vecs[12] = '{"ea_wrap",   16'h2405, 16'h847F, 16'hB87F, 16'hE001, 16'h0000, 16'h0000, 6, 16'h0005, 10};
        vecs[13] = '{"self_mod",  16'h6780, 16'h2481, 16'h8404, 16'h2801, 16'h2C01, 16'hE001, 3, 16'h0000, 11};

        #1 rstn = 1'b0;

        // Reset hold and first fetch
        holdReset(5);
        clearMem();
        dut.mem[0] = 16'h2405; dut.mem[1] = 16'h287F; dut.mem[2] = 16'h0C82; dut.mem[3] = 16'hE001;
        checkOutput("reset halt", 32'(halt), 32'd0);
        checkOutput("reset pc", 32'(dut.pc), 32'd0);
        checkOutput("reset ir", 32'(dut.ir), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("first fetch ir", 32'(dut.ir), 32'h2405);
        checkOutput("first fetch pc", 32'(dut.pc), 32'd1);

        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i]);

        // Store lands on the fifth edge; then halt is sticky with no writes
        holdReset(2);
        clearMem();
        dut.mem[0] = 16'h2405; dut.mem[1] = 16'h8410; dut.mem[2] = 16'hB410; dut.mem[3] = 16'hE001;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1 checkOutput("sw before edge5", 32'(dut.mem[16]), 32'd0);
        @(posedge clk);
        #1 checkOutput("sw at edge5", 32'(dut.mem[16]), 32'd5);
        cyc = 5;
        while (!halt && cyc < 100) begin
            @(posedge clk); cyc++; #1;
        end
        checkOutput("mem seq cycles", cyc, 10);
        checkOutput("mem seq r5", 32'(dut.rf[5]), 32'd5);
        pc_snap = dut.pc;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (!halt || dut.pc !== pc_snap) bad++;
        end
        checkOutput("halt sticky", bad, 0);
        checkOutput("halt no mem write", 32'(dut.mem[16]), 32'd5);
        checkOutput("halt code intact", 32'(dut.mem[3]), 32'hE001);

        // Asynchronous reset clears halt without a clock edge
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async halt", 32'(halt), 32'd0);
        checkOutput("async pc", 32'(dut.pc), 32'd0);
        checkOutput("async r5", 32'(dut.rf[5]), 32'd0);
        runToHalt(cyc);
        checkOutput("rerun cycles", cyc, 10);
        checkOutput("rerun r5", 32'(dut.rf[5]), 32'd5);

        for (int n = 0; n < 8; n++)
            randomProgram(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/my_risc16.md
# my_risc16

Self-contained 16-bit, word-addressed RISC processor core (RiSC-16-style ISA) with an internal 64K x 16 unified instruction/data memory. After reset it fetches and executes from address 0x0000 and raises `halt` when it executes a halt instruction. The memory is preloaded externally by hierarchical access. Top-level CPU block for the iverilog simulation flow.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `halt`  output  1  registered; 1 once a halt instruction has executed. Sticky until reset.
- Internal memory array must be named `mem`, declared `reg [15:0] mem [0:65535]`. It is hierarchically loadable (`$readmemh` over 0x0000–0xFFFF), is never cleared by reset, and is word-addressed.

## Operation
- Register file: 8 x 16-bit, r0..r7. r0 reads as 0 and writes to it are discarded. PC is 16-bit, 0x0000 at reset.
- Instruction fields: op = [15:13], rA = [12:10], rB = [9:7], rC = [2:0], imm7 = [6:0] (sign-extended), imm10 = [9:0].
- 000 ADD: rA = rB + rC, modulo 2^16.
- 001 ADDI: rA = rB + sext(imm7).
- 010 NAND: rA = ~(rB & rC).
- 011 LUI: rA = {imm10, 6'b0}.
- 100 SW: mem[rB + sext(imm7)] = rA.
- 101 LW: rA = mem[rB + sext(imm7)].
- 110 BEQ: if rA == rB, PC = PC+1 + sext(imm7); otherwise PC = PC+1.
- 111 JALR with imm7 == 0: rA = PC+1, PC = rB. Both use the old rB value, so rA == rB is well defined.
- 111 JALR with imm7 != 0: HALT. Set `halt` = 1, enter the HALT state, and make no register or PC change.
- Address arithmetic wraps modulo 2^16. This applies to PC increments and to effective addresses.
- Bits [6:3] of RRR instructions are ignored.
- State machine: FETCH → EXEC → (MEM only for LW/SW) → FETCH. HALT is terminal.
  - FETCH: IR <= mem[PC]; PC <= PC+1.
  - EXEC: ALU ops, LUI, BEQ and JALR complete here. LW/SW compute the effective address into an address register.
  - MEM: SW writes mem, or LW writes rA.
  - HALT: no further fetches or memory writes until reset.

## Timing
- Reset (async, `rstn`=0): PC=0, r1..r7=0, IR=0, state=FETCH, `halt`=0, effective immediately without a clock.
- First fetch occurs on the first rising edge with `rstn`=1.
- Latency: ALU, LUI, BEQ, JALR take 2 cycles; LW and SW take 3 cycles.
- `halt` rises at the clock edge that completes EXEC of the halt instruction. It stays 1 until `rstn` goes low.
- Memory reads are combinational from `mem` within the cycle. Memory writes happen on the rising edge.
- An instruction fetched after a SW to its own address sees the new value (self-modifying code allowed).
- Reset asserted mid-instruction aborts that instruction. Any register or memory write not yet clocked is lost.

## Test plan
- Reset: hold `rstn`=0 for 5 cycles → `halt`=0 and PC=0. Release → first fetch is from mem[0x0000].
- Arithmetic: program 0x2405 (addi r1,r0,5), 0x287F (addi r2,r0,-1), 0x0C82 (add r3,r1,r2), 0xE001 (halt) → r1=0x0005, r2=0xFFFF, r3=0x0004. `halt` is 1 after 8 cycles past reset release and stays 1.
- LUI/NAND/r0: 0x73FF (lui r4,0x3FF) → r4=0xFFC0. NAND r5,r4,r4 (0x5604) → r5=0x003F. ADDI r0,r0,7 (0x2007) → r0 still reads 0.
- Memory: r1=5, then 0x8410 (sw r1,[r0+16]) and 0xB410 (lw r5,[r0+16]) → mem[0x0010]=0x0005 and r5=0x0005. Each of the two instructions takes 3 cycles.
- Branch/jump: 0xC001 (beq r0,r0,+1) skips the next word. A not-taken BEQ falls through. JALR r7,r6 with r6=0x0020 → r7=PC+1 and execution continues at 0x0020.
- Halt sticky/re-reset: after halt, 100 further cycles show no memory writes and `halt`=1. Pulse `rstn` low → `halt`=0 immediately and the program re-executes from 0x0000.
